// File: rtl/obi_spi_pkg.sv
// Shared definitions for the OBI SPI transmitter/receiver pair:
// register word indices, CTRL/STATUS bit positions and the receiver FSM states.
package obi_spi_pkg;

    // Register byte offsets on the OBI bus
    localparam logic [31:0] SPI_CTRL_OFFSET   = 32'h0;
    localparam logic [31:0] SPI_RX_OFFSET     = 32'h4;
    localparam logic [31:0] SPI_STATUS_OFFSET = 32'h8;

    // Word indices decoded from addr[3:2]
    localparam logic [1:0] SPI_CTRL_IDX   = 2'd0;
    localparam logic [1:0] SPI_RX_IDX     = 2'd1;
    localparam logic [1:0] SPI_STATUS_IDX = 2'd2;

    // CTRL bit positions
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_FLUSH_BIT  = 2;

    // STATUS bit positions (count occupies [7:4])
    localparam int STATUS_EMPTY_BIT     = 0;
    localparam int STATUS_FULL_BIT      = 1;
    localparam int STATUS_OVERFLOW_BIT  = 2;
    localparam int STATUS_FRAME_ERR_BIT = 3;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_PUSH = 2'd2
    } rx_state_t;

    // Clamp a FIFO occupancy into the 4-bit STATUS count field
    function automatic logic [3:0] sat_count4(input int unsigned c);
        logic [3:0] r;
        if (c > 32'd15) r = 4'hF;
        else            r = c[3:0];
        return r;
    endfunction

endpackage

// File: rtl/obi_spi_receiver_if.sv
// OBI request/response bundle between a bus master and the SPI receiver.
interface obi_spi_receiver_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input gnt, input rvalid, input rdata);
    modport slave  (input req, input we, input addr, input wdata,
                    output gnt, output rvalid, output rdata);
endinterface

// File: rtl/spi_rx_fifo.sv
// Small synchronous FIFO for received bytes. Flush has priority over push/pop;
// a pop in the same cycle as a push into a full FIFO makes room for the push.
module spi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] pop_data,
    output logic             push_drop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign push_drop = push & ~do_push & ~flush;
    assign pop_data  = mem[rd_ptr_reg];

    // Storage write; contents need no reset since pointers define validity
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_reg] <= push_data;
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/obi_spi_receiver.sv
// SPI mode 0 target: synchronises the SPI pins into clk_i, shifts bytes in
// MSB-first, queues them in an RX FIFO and exposes CTRL/RXDATA/STATUS over OBI.
module obi_spi_receiver
    import obi_spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    obi_spi_receiver_if.slave       bus,
    input  logic                    sck_i,
    input  logic                    mosi_i,
    input  logic                    cs_ni,
    output logic                    irq_o
);

    // Synchroniser lanes packed as {sck, cs_n, mosi}; idle = sck 0, cs_n 1, mosi 0
    localparam logic [2:0] SYNC_IDLE = 3'b010;

    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic        sck_s, cs_n_s, mosi_s;
    logic        sck_prev_reg;
    logic        sck_rise;

    rx_state_t   state_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;

    logic        ctrl_en_reg;
    logic        ctrl_irq_en_reg;
    logic        frame_err_reg;
    logic        overflow_reg;
    logic        rvalid_reg;
    logic [31:0] rdata_reg;
    logic [31:0] rdata_next;

    logic        rd_req, wr_req;
    logic [1:0]  word_idx;
    logic        fifo_push, fifo_pop, fifo_flush;
    logic [7:0]  fifo_head;
    logic        fifo_drop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic        frame_err_evt;
    logic        unused_bits;

    assign sck_s  = sync_reg[SYNC_STAGES-1][2];
    assign cs_n_s = sync_reg[SYNC_STAGES-1][1];
    assign mosi_s = sync_reg[SYNC_STAGES-1][0];
    assign sck_rise = sck_s & ~sck_prev_reg;

    // Multi-flop synchroniser for the asynchronous SPI pins plus sck edge history
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_reg     <= {SYNC_STAGES{SYNC_IDLE}};
            sck_prev_reg <= 1'b0;
        end else begin
            if (SYNC_STAGES > 1)
                sync_reg <= {sync_reg[SYNC_STAGES-2:0], {sck_i, cs_ni, mosi_i}};
            else
                sync_reg <= {sck_i, cs_ni, mosi_i};
            sck_prev_reg <= sck_s;
        end
    end

    // Receive FSM: collect 8 bits per byte, hand complete bytes to the FIFO
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= RX_IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'd0;
        end else if (!ctrl_en_reg) begin
            state_reg   <= RX_IDLE;
            bit_cnt_reg <= 3'd0;
        end else begin
            case (state_reg)
                RX_IDLE: begin
                    bit_cnt_reg <= 3'd0;
                    if (!cs_n_s) state_reg <= RX_RECV;
                end
                RX_RECV: begin
                    if (cs_n_s) begin
                        // Deselect ends the frame; any partial byte is dropped
                        state_reg   <= RX_IDLE;
                        bit_cnt_reg <= 3'd0;
                    end else if (sck_rise) begin
                        shift_reg   <= {shift_reg[6:0], mosi_s};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) state_reg <= RX_PUSH;
                    end
                end
                RX_PUSH: begin
                    bit_cnt_reg <= 3'd0;
                    state_reg   <= cs_n_s ? RX_IDLE : RX_RECV;
                end
                default: begin
                    state_reg   <= RX_IDLE;
                    bit_cnt_reg <= 3'd0;
                end
            endcase
        end
    end

    assign fifo_push     = (state_reg == RX_PUSH) && ctrl_en_reg;
    assign frame_err_evt = (state_reg == RX_RECV) && ctrl_en_reg && cs_n_s
                           && (bit_cnt_reg != 3'd0);

    // Bus decode; only addr[3:2] selects a register
    assign word_idx   = bus.addr[3:2];
    assign rd_req     = bus.req & ~bus.we;
    assign wr_req     = bus.req & bus.we;
    assign fifo_pop   = rd_req && (word_idx == SPI_RX_IDX);
    assign fifo_flush = wr_req && (word_idx == SPI_CTRL_IDX) && bus.wdata[CTRL_FLUSH_BIT];

    spi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (fifo_push),
        .push_data (shift_reg),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .pop_data  (fifo_head),
        .push_drop (fifo_drop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Read data mux for the addressed register
    always_comb begin
        rdata_next = 32'd0;
        case (word_idx)
            SPI_CTRL_IDX:   rdata_next = {30'd0, ctrl_irq_en_reg, ctrl_en_reg};
            SPI_RX_IDX:     rdata_next = fifo_empty ? 32'd0 : {24'd0, fifo_head};
            SPI_STATUS_IDX: rdata_next = {24'd0, sat_count4(32'(fifo_count)),
                                          frame_err_reg, overflow_reg,
                                          fifo_full, fifo_empty};
            default:        rdata_next = 32'd0;
        endcase
    end

    // Register file, sticky flags (set beats W1C) and the registered OBI response
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en_reg     <= 1'b0;
            ctrl_irq_en_reg <= 1'b0;
            frame_err_reg   <= 1'b0;
            overflow_reg    <= 1'b0;
            rvalid_reg      <= 1'b0;
            rdata_reg       <= 32'd0;
        end else begin
            rvalid_reg <= bus.req;
            rdata_reg  <= rd_req ? rdata_next : 32'd0;
            if (wr_req && (word_idx == SPI_CTRL_IDX)) begin
                ctrl_en_reg     <= bus.wdata[CTRL_EN_BIT];
                ctrl_irq_en_reg <= bus.wdata[CTRL_IRQ_EN_BIT];
            end
            if (frame_err_evt)
                frame_err_reg <= 1'b1;
            else if (wr_req && (word_idx == SPI_STATUS_IDX) && bus.wdata[STATUS_FRAME_ERR_BIT])
                frame_err_reg <= 1'b0;
            if (fifo_drop)
                overflow_reg <= 1'b1;
            else if (wr_req && (word_idx == SPI_STATUS_IDX) && bus.wdata[STATUS_OVERFLOW_BIT])
                overflow_reg <= 1'b0;
        end
    end

    assign bus.gnt    = bus.req;
    assign bus.rvalid = rvalid_reg;
    assign bus.rdata  = rdata_reg;
    assign irq_o      = ctrl_irq_en_reg & ~fifo_empty;

    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.wdata[31:4]};

endmodule

// File: tb/tb_obi_spi_receiver.sv
// Directed bench for obi_spi_receiver: drives SPI mode 0 frames on the pins and
// checks register reads against hand-computed values.
module tb_obi_spi_receiver;

    logic clk = 1'b0;
    logic rst;
    logic sck, mosi, cs_n;
    logic irq;
    int   pass_cnt = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    obi_spi_receiver_if bus ();

    obi_spi_receiver #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus.slave),
        .sck_i  (sck),
        .mosi_i (mosi),
        .cs_ni  (cs_n),
        .irq_o  (irq)
    );

    // One OBI transaction; called at a negedge, returns at the following negedge
    task automatic obi_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic gnt_seen, output logic rvalid_seen,
                              output logic [31:0] rdata);
        bus.req = 1'b1; bus.we = we; bus.addr = addr; bus.wdata = wdata;
        #1 gnt_seen = bus.gnt;
        @(posedge clk);
        @(negedge clk);
        rvalid_seen = bus.rvalid;
        rdata = bus.rdata;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        $display("obi %s addr=%h wdata=%h rdata=%h rvalid=%b", we ? "wr" : "rd",
                 addr, wdata, rdata, rvalid_seen);
    endtask

    task automatic obi_write(input logic [31:0] addr, input logic [31:0] wdata);
        logic g, v; logic [31:0] d;
        obi_access(1'b1, addr, wdata, g, v, d);
    endtask

    task automatic obi_read(input logic [31:0] addr, output logic [31:0] rdata);
        logic g, v;
        obi_access(1'b0, addr, 32'd0, g, v, rdata);
    endtask

    // Shift n bits MSB-first (8 clk per sck period). With pop_last, an RXDATA
    // read is placed exactly in the PUSH cycle that follows the last rising edge.
    task automatic send_bits(input logic [7:0] data, input int n, input bit pop_last,
                             output logic [31:0] popped);
        popped = 32'd0;
        for (int i = 0; i < n; i++) begin
            mosi = data[7-i];
            repeat (4) @(negedge clk);
            sck = 1'b1;
            if (pop_last && i == n - 1) begin
                repeat (3) @(negedge clk);
                obi_read(32'h4, popped);
            end else begin
                repeat (4) @(negedge clk);
            end
            sck = 1'b0;
        end
    endtask

    task automatic frame_begin();
        cs_n = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame_end();
        repeat (2) @(negedge clk);
        cs_n = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        total_cnt++; if (bus.gnt !== 1'b0) $display("FAIL reset_gnt got=%b exp=0", bus.gnt); else pass_cnt++;
        total_cnt++; if (bus.rvalid !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", bus.rvalid); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 32'd0) $display("FAIL reset_rdata got=%h exp=0", bus.rdata); else pass_cnt++;
        total_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else pass_cnt++;
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h1) $display("FAIL reset_status got=%h exp=%h", d, 32'h1); else pass_cnt++;
        obi_read(32'h0, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h0); else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [31:0] d; logic g, v;
        obi_write(32'h0, 32'h1);
        frame_begin();
        send_bits(8'hA5, 8, 1'b0, d);
        frame_end();
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h10) $display("FAIL basic_status got=%h exp=%h", d, 32'h10); else pass_cnt++;
        obi_access(1'b0, 32'h4, 32'd0, g, v, d);
        total_cnt++; if (g !== 1'b1) $display("FAIL basic_gnt got=%b exp=1", g); else pass_cnt++;
        total_cnt++; if (v !== 1'b1) $display("FAIL basic_rvalid got=%b exp=1", v); else pass_cnt++;
        total_cnt++; if (d !== 32'hA5) $display("FAIL basic_rxdata got=%h exp=%h", d, 32'hA5); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.rvalid !== 1'b0) $display("FAIL basic_rvalid_drop got=%b exp=0", bus.rvalid); else pass_cnt++;
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h1) $display("FAIL basic_status_empty got=%h exp=%h", d, 32'h1); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0] bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        frame_begin();
        for (int i = 0; i < 5; i++) send_bits(bytes[i], 8, 1'b0, d);
        frame_end();
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h46) $display("FAIL ovf_status got=%h exp=%h", d, 32'h46); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            obi_read(32'h4, d);
            total_cnt++; if (d !== {24'd0, bytes[i]}) $display("FAIL ovf_read%0d got=%h exp=%h", i, d, {24'd0, bytes[i]}); else pass_cnt++;
        end
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h05) $display("FAIL ovf_status_drained got=%h exp=%h", d, 32'h05); else pass_cnt++;
        obi_write(32'h8, 32'h4);
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h01) $display("FAIL ovf_w1c got=%h exp=%h", d, 32'h01); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        logic [31:0] d;
        frame_begin();
        send_bits(8'hE8, 5, 1'b0, d);
        frame_end();
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h09) $display("FAIL ferr_status got=%h exp=%h", d, 32'h09); else pass_cnt++;
        frame_begin();
        send_bits(8'h3C, 8, 1'b0, d);
        frame_end();
        obi_read(32'h4, d);
        total_cnt++; if (d !== 32'h3C) $display("FAIL ferr_next_byte got=%h exp=%h", d, 32'h3C); else pass_cnt++;
        obi_write(32'h8, 32'h8);
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h01) $display("FAIL ferr_w1c got=%h exp=%h", d, 32'h01); else pass_cnt++;
    endtask

    task automatic test_push_pop_full();
        logic [31:0] d;
        logic [7:0] exp_rest [4] = '{8'hA2, 8'hA3, 8'hA4, 8'h99};
        frame_begin();
        send_bits(8'hA1, 8, 1'b0, d);
        send_bits(8'hA2, 8, 1'b0, d);
        send_bits(8'hA3, 8, 1'b0, d);
        send_bits(8'hA4, 8, 1'b0, d);
        send_bits(8'h99, 8, 1'b1, d);
        frame_end();
        total_cnt++; if (d !== 32'hA1) $display("FAIL pp_popped got=%h exp=%h", d, 32'hA1); else pass_cnt++;
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h42) $display("FAIL pp_status got=%h exp=%h", d, 32'h42); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            obi_read(32'h4, d);
            total_cnt++; if (d !== {24'd0, exp_rest[i]}) $display("FAIL pp_read%0d got=%h exp=%h", i, d, {24'd0, exp_rest[i]}); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midbyte();
        logic [31:0] d;
        obi_write(32'h0, 32'h3);
        frame_begin();
        send_bits(8'h5A, 8, 1'b0, d);
        repeat (4) @(negedge clk);
        total_cnt++; if (irq !== 1'b1) $display("FAIL rst_pre_irq got=%b exp=1", irq); else pass_cnt++;
        send_bits(8'hF0, 4, 1'b0, d);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (irq !== 1'b0) $display("FAIL rst_irq got=%b exp=0", irq); else pass_cnt++;
        total_cnt++; if (bus.rvalid !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", bus.rvalid); else pass_cnt++;
        total_cnt++; if (bus.rdata !== 32'd0) $display("FAIL rst_rdata got=%h exp=0", bus.rdata); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        cs_n = 1'b1;
        repeat (4) @(negedge clk);
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h01) $display("FAIL rst_status got=%h exp=%h", d, 32'h01); else pass_cnt++;
        obi_write(32'h0, 32'h1);
        frame_begin();
        send_bits(8'h0F, 8, 1'b0, d);
        frame_end();
        obi_read(32'h4, d);
        total_cnt++; if (d !== 32'h0F) $display("FAIL rst_next_byte got=%h exp=%h", d, 32'h0F); else pass_cnt++;
    endtask

    task automatic test_irq_flush();
        logic [31:0] d;
        obi_write(32'h0, 32'h3);
        frame_begin();
        send_bits(8'h7E, 8, 1'b0, d);
        frame_end();
        total_cnt++; if (irq !== 1'b1) $display("FAIL irq_set got=%b exp=1", irq); else pass_cnt++;
        obi_write(32'h0, 32'h7);
        total_cnt++; if (irq !== 1'b0) $display("FAIL irq_after_flush got=%b exp=0", irq); else pass_cnt++;
        obi_read(32'h8, d);
        total_cnt++; if (d !== 32'h01) $display("FAIL flush_status got=%h exp=%h", d, 32'h01); else pass_cnt++;
        obi_read(32'h4, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL flush_rx_empty got=%h exp=%h", d, 32'h0); else pass_cnt++;
        obi_read(32'h0, d);
        total_cnt++; if (d !== 32'h3) $display("FAIL ctrl_readback got=%h exp=%h", d, 32'h3); else pass_cnt++;
        obi_read(32'hC, d);
        total_cnt++; if (d !== 32'h0) $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0); else pass_cnt++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sck = 1'b0; mosi = 1'b0; cs_n = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_frame_err();
        test_push_pop_full();
        test_reset_midbyte();
        test_irq_flush();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
